video_frame_checker: RTL and testbench
======================================

Name: video_frame_checker

Overview:
- Receive-side monitor for the VGA pixel path; the consumer counterpart to the test pattern generator.
- Samples the same timing and RGB signals that drive the DAC pins (de, hsync, vsync, 3/3/3 RGB).
- Each frame it measures active geometry and line period, and computes a CRC-16 signature of active pixels.
- Reports per-frame results to debug LEDs/UART, so the generator can be checked in-system without a monitor.

Parameters:
H_ACTIVE, 640, expected active pixels per line
V_ACTIVE, 480, expected active lines per frame
HSYNC_POL, 0, hsync active level (0 = active-low)
VSYNC_POL, 0, vsync active level (0 = active-low)

Ports:
clk_pix  in  1  pixel clock (~25 MHz)
reset  in  1  synchronous, active-high reset
de  in  1  data enable, high in active area
hsync  in  1  horizontal sync
vsync  in  1  vertical sync
rgb_r  in  3  red
rgb_g  in  3  green
rgb_b  in  3  blue
frame_done  out  1  one-cycle pulse; results below updated in the same cycle
meas_width  out  10  active pixels per line (from first line of frame)
meas_lines  out  10  active lines in frame
meas_htotal  out  10  clocks between last two hsync active edges
frame_sig  out  16  CRC-16 of frame's active pixels
fmt_ok  out  1  width==H_ACTIVE, lines==V_ACTIVE, no line_err
sig_stable  out  1  frame_sig equals previous frame's frame_sig
frame_count  out  16  completed frames, wraps at 0xFFFF->0
pix_err_count  out  16  colour-bar mismatches (CHK_COLOUR_BAR_EN only, else 0)

Behaviour:
- Reset: all outputs 0; state SEARCH; all accumulators and edge registers cleared. Reset mid-frame discards that frame.
- Edge detect: de, hsync and vsync are registered once.
  - Vsync active edge: prev inactive, current active, per VSYNC_POL.
  - Hsync active edge: likewise, per HSYNC_POL.
  - de falling edge: prev 1, current 0.
- SEARCH: ignore all data. On vsync active edge, clear accumulators and go to MEASURE. No frame_done is generated.
- MEASURE:
  - While de=1: x_cnt increments, saturating at 1023. CRC updates with pixel {rgb_r,rgb_g,rgb_b}, 9 bits MSB first, unrolled to one pixel per clock. CRC is poly 0x1021, init 0xFFFF, no reflection, no final XOR.
  - de falling edge, first line of frame: store ref_width=x_cnt.
  - de falling edge, later lines: x_cnt != ref_width sets sticky line_err.
  - Every de falling edge: line_cnt increments (saturate 1023); x_cnt clears.
  - hsync active edge: h_total_last = h_cnt; h_cnt restarts at 1. Otherwise h_cnt increments, saturating at 1023.
  - Vsync active edge sampled in cycle N: in cycle N+1 frame_done=1, and all results latch.
    - meas_width=ref_width; meas_lines=line_cnt; meas_htotal=h_total_last; frame_sig=crc.
    - fmt_ok per definition above.
    - sig_stable = (crc==frame_sig_prev) AND a previous frame exists.
    - frame_count increments.
    - Accumulators reset: crc=0xFFFF, line_cnt=0, line_err=0, first-line flag set.
  - A de-high pixel in the same cycle as the vsync edge belongs to the new frame.
  - Frame with zero active lines: meas_width=0, meas_lines=0, fmt_ok=0, frame_sig=0xFFFF.
- Line ending exactly at vsync edge with de still high: that partial line is not counted (no de falling edge before boundary).
- Outputs hold between frame_done pulses.

Optional Feature:
- Macro: CHK_COLOUR_BAR_EN.
- Defined: each active pixel is compared against the expected colour-bar pattern, using x = x_cnt before increment.
  - Bar b = x/80.
  - b=0: expect 000/000/000.
  - b>=1, (b-1)%3 == 0: red 111, others 000.
  - (b-1)%3 == 1: green 111, others 000.
  - (b-1)%3 == 2: blue 111, others 000.
  - Mismatches count in a saturating 16-bit counter, latched to pix_err_count at frame_done, then cleared.
- Undefined: pix_err_count tied 0; no comparison logic.

Test Plan:
- Reset held 3 cycles mid-stream -> all outputs 0; first vsync edge after release gives no frame_done; second gives frame_done with frame_count=1.
- Two identical 800x525 frames (640x480 active, negative syncs) of constant 3'b111 white -> meas_width=640, meas_lines=480, meas_htotal=800, fmt_ok=1. Frame 2: sig_stable=1, frame_sig equal to frame 1.
- Second frame with one pixel changed at (100,200) -> frame_sig differs, sig_stable=0; third frame unchanged from second -> sig_stable=1.
- Line 10 shortened to 639 active pixels -> meas_width=640, fmt_ok=0; next clean frame -> fmt_ok=1 (line_err cleared).
- frame_count preset by running 65535 frames (or forced) -> next frame_done wraps frame_count to 0; de held high 1100 cycles -> x_cnt saturates, meas_width=1023.
- CHK_COLOUR_BAR_EN: correct bar frame -> pix_err_count=0; x=80..159 driven green instead of red on all 480 lines -> pix_err_count=38400.

Source files
------------

// File: rtl/video_frame_if.sv
// Pixel-path bundle sampled at the DAC pins: timing strobes plus 3/3/3 RGB.
// Stream semantics: a pixel is transferred on every clk_pix edge where de=1;
// there is no ready/backpressure, the sink must accept every cycle.
interface video_frame_if;
  logic       de;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb_r;
  logic [2:0] rgb_g;
  logic [2:0] rgb_b;

  modport master (output de, hsync, vsync, rgb_r, rgb_g, rgb_b);
  modport slave  (input  de, hsync, vsync, rgb_r, rgb_g, rgb_b);
endinterface

// File: rtl/video_frame_checker.sv
// Receive-side frame monitor: measures active geometry, line period and a
// CRC-16 (poly 0x1021, init 0xFFFF, MSB first) over active pixels per frame.
// Optional macro CHK_COLOUR_BAR_EN adds a colour-bar pixel comparison and
// a per-frame mismatch count on pix_err_count.
module video_frame_checker #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0
) (
  input  logic        clk_pix,
  input  logic        reset,
  video_frame_if.slave vid,
  output logic        frame_done,
  output logic [9:0]  meas_width,
  output logic [9:0]  meas_lines,
  output logic [9:0]  meas_htotal,
  output logic [15:0] frame_sig,
  output logic        fmt_ok,
  output logic        sig_stable,
  output logic [15:0] frame_count,
  output logic [15:0] pix_err_count,
  output logic        dbg_state
);

  localparam logic [0:0] SEARCH  = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;
  localparam logic       HS_ACT  = (HSYNC_POL != 0);
  localparam logic       VS_ACT  = (VSYNC_POL != 0);
  localparam logic [9:0] SAT     = 10'd1023;
  localparam logic [9:0] H_EXP   = 10'(H_ACTIVE);
  localparam logic [9:0] V_EXP   = 10'(V_ACTIVE);

  logic [0:0]  state;
  logic        de_q, hs_q, vs_q;
  logic        vs_edge, hs_edge, de_fall, active;
  logic [8:0]  pixel;
  logic [9:0]  x_cnt, ref_width, line_cnt, h_cnt, h_total_last;
  logic        first_line, line_err, have_prev;
  logic [15:0] crc;

  // Frame-relative base values: a vsync edge starts the new frame this cycle.
  logic [9:0]  x_b, ref_b, line_b;
  logic        first_b, err_b;
  logic [15:0] crc_b;
  logic [9:0]  x_nxt, ref_nxt, line_nxt;
  logic        first_nxt, err_nxt;
  logic [15:0] crc_nxt;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [8:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 8; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign pixel     = {vid.rgb_r, vid.rgb_g, vid.rgb_b};
  assign vs_edge   = (vs_q != VS_ACT) && (vid.vsync == VS_ACT);
  assign hs_edge   = (hs_q != HS_ACT) && (vid.hsync == HS_ACT);
  assign de_fall   = de_q && !vid.de;
  assign active    = (state == MEASURE) || vs_edge;
  assign dbg_state = state;

  // Next-state of the per-frame accumulators; a pixel in the vsync-edge
  // cycle belongs to the new frame, a line ending in that cycle is dropped.
  always_comb begin
    x_b       = vs_edge ? 10'd0 : x_cnt;
    ref_b     = vs_edge ? 10'd0 : ref_width;
    line_b    = vs_edge ? 10'd0 : line_cnt;
    first_b   = vs_edge ? 1'b1 : first_line;
    err_b     = vs_edge ? 1'b0 : line_err;
    crc_b     = vs_edge ? 16'hFFFF : crc;
    x_nxt     = x_b;
    ref_nxt   = ref_b;
    line_nxt  = line_b;
    first_nxt = first_b;
    err_nxt   = err_b;
    crc_nxt   = crc_b;
    if (vid.de) begin
      x_nxt   = (x_b == SAT) ? SAT : x_b + 10'd1;
      crc_nxt = crc_step(crc_b, pixel);
    end else begin
      x_nxt = 10'd0;
      if (de_fall && !vs_edge) begin
        if (first_b) begin
          ref_nxt   = x_b;
          first_nxt = 1'b0;
        end else if (x_b != ref_b) begin
          err_nxt = 1'b1;
        end
        line_nxt = (line_b == SAT) ? SAT : line_b + 10'd1;
      end
    end
  end

  // Edge registers, frame FSM, accumulators and latched per-frame results.
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state        <= SEARCH;
      de_q         <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      x_cnt        <= '0;
      ref_width    <= '0;
      line_cnt     <= '0;
      h_cnt        <= '0;
      h_total_last <= '0;
      first_line   <= 1'b1;
      line_err     <= 1'b0;
      have_prev    <= 1'b0;
      crc          <= 16'hFFFF;
      frame_done   <= 1'b0;
      meas_width   <= '0;
      meas_lines   <= '0;
      meas_htotal  <= '0;
      frame_sig    <= '0;
      fmt_ok       <= 1'b0;
      sig_stable   <= 1'b0;
      frame_count  <= '0;
    end else begin
      de_q       <= vid.de;
      hs_q       <= vid.hsync;
      vs_q       <= vid.vsync;
      frame_done <= 1'b0;
      if (active) begin
        x_cnt      <= x_nxt;
        ref_width  <= ref_nxt;
        line_cnt   <= line_nxt;
        first_line <= first_nxt;
        line_err   <= err_nxt;
        crc        <= crc_nxt;
        if (hs_edge) begin
          h_total_last <= h_cnt;
          h_cnt        <= 10'd1;
        end else if (h_cnt != SAT) begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
      if (vs_edge) begin
        state <= MEASURE;
        if (state == MEASURE) begin
          frame_done  <= 1'b1;
          meas_width  <= ref_width;
          meas_lines  <= line_cnt;
          meas_htotal <= h_total_last;
          frame_sig   <= crc;
          fmt_ok      <= (ref_width == H_EXP) && (line_cnt == V_EXP) && !line_err;
          sig_stable  <= have_prev && (crc == frame_sig);
          have_prev   <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

`ifdef CHK_COLOUR_BAR_EN
  logic [15:0] pix_acc, pix_base;
  logic        pix_bad;

  function automatic logic [8:0] bar_pixel(input logic [9:0] x);
    logic [9:0] b;
    b = x / 10'd80;
    if (b == 10'd0) return 9'b000_000_000;
    case ((b - 10'd1) % 10'd3)
      10'd0:   return 9'b111_000_000;
      10'd1:   return 9'b000_111_000;
      default: return 9'b000_000_111;
    endcase
  endfunction

  assign pix_bad  = vid.de && (pixel != bar_pixel(x_b));
  assign pix_base = vs_edge ? 16'd0 : pix_acc;

  // Saturating colour-bar mismatch count, reported and cleared per frame.
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      pix_acc       <= '0;
      pix_err_count <= '0;
    end else if (active) begin
      if (vs_edge && (state == MEASURE)) pix_err_count <= pix_acc;
      pix_acc <= (pix_bad && (pix_base != 16'hFFFF)) ? pix_base + 16'd1 : pix_base;
    end
  end
`else
  assign pix_err_count = '0;
`endif

endmodule

// File: tb/tb_video_frame_checker.sv
// Bench for video_frame_checker with reduced geometry (200x4 active,
// 240-clock lines). Table of frame scenarios plus random frames, all checked
// against a frame-level model; build with CHK_COLOUR_BAR_EN to cover bars.
module tb_video_frame_checker;
  localparam int H_ACT = 200;
  localparam int V_ACT = 4;
  localparam int H_TOT = 240;

  typedef struct packed {
    logic [9:0]  width;
    logic [9:0]  lines;
    logic [9:0]  htotal;
    logic [15:0] sig;
    logic        fmt_ok;
    logic        stable;
    logic [15:0] count;
    logic [15:0] pix;
  } exp_t;

  typedef struct {
    int         kind;
    int         act;
    int         first_len;
    int         short_y;
    int         short_len;
    logic [9:0] width;
    logic [9:0] lines;
    logic       fmt_ok;
    logic       stable;
  } row_t;

  logic        clk_pix = 1'b0;
  logic        reset = 1'b0;
  logic        frame_done, fmt_ok, sig_stable, dbg_state;
  logic [9:0]  meas_width, meas_lines, meas_htotal;
  logic [15:0] frame_sig, frame_count, pix_err_count;

  video_frame_if vif ();

  video_frame_checker #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .HSYNC_POL(0), .VSYNC_POL(0)
  ) dut (
    .clk_pix(clk_pix), .reset(reset), .vid(vif),
    .frame_done(frame_done), .meas_width(meas_width), .meas_lines(meas_lines),
    .meas_htotal(meas_htotal), .frame_sig(frame_sig), .fmt_ok(fmt_ok),
    .sig_stable(sig_stable), .frame_count(frame_count),
    .pix_err_count(pix_err_count), .dbg_state(dbg_state)
  );

  // ---- clock ----
  always #5 clk_pix = ~clk_pix;

  // ---- bookkeeping and model state ----
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        prev_hs = 1'b1;
  logic        have_prev = 1'b0;
  logic [15:0] prev_sig = '0;
  logic [15:0] m_count = '0;
  exp_t        exp_q[$];
  exp_t        last_out = '0;
  logic        hold_bad = 1'b0;
  exp_t        hold_act = '0;
  exp_t        hold_exp = '0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic hold_check();
    checks++;
    if (hold_bad) begin
      errors++;
      $display("FAIL hold: outputs moved between frame_done pulses, got %h expected %h", hold_act, hold_exp);
    end
    hold_bad = 1'b0;
  endtask

  // CRC-16/0x1021 as polynomial division: (crc*x^9 + d*x^16) mod P.
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [8:0] d);
    logic [24:0] r;
    r = {c, 9'b0} ^ {d, 16'b0};
    for (int i = 24; i >= 16; i--)
      if (r[i]) r = r ^ (25'h11021 << (i - 16));
    return r[15:0];
  endfunction

  function automatic logic [8:0] bar_rgb(input int x);
    int b;
    b = x / 80;
    if (b == 0) return 9'b000_000_000;
    case ((b - 1) % 3)
      0:       return 9'b111_000_000;
      1:       return 9'b000_111_000;
      default: return 9'b000_000_111;
    endcase
  endfunction

  function automatic logic [8:0] pixel_for(input int kind, input int x, input int y);
    case (kind)
      1:       return (x == 100 && y == 2) ? 9'h000 : 9'h1FF;
      2:       return 9'($urandom_range(0, 511));
      3:       return bar_rgb(x);
      4:       return (x >= 80 && x < 160) ? 9'b000_111_000 : bar_rgb(x);
      default: return 9'h1FF;
    endcase
  endfunction

  // ---- driver ----
  task automatic drive(input logic d, input logic h, input logic v, input logic [8:0] p);
    @(posedge clk_pix);
    #1;
    vif.de    = d;
    vif.hsync = h;
    vif.vsync = v;
    {vif.rgb_r, vif.rgb_g, vif.rgb_b} = p;
    cyc++;
  endtask

  // One frame: vsync line, porch line, act active lines, two porch lines.
  // Returns the frame's expected report (done=0 if aborted early).
  task automatic send_frame(input int kind, input int act, input int first_len,
                            input int short_y, input int short_len, input int abort_after,
                            output exp_t e, output logic done);
    int n, first_w, nlines, pe, t_prev, t_last, diff;
    logic err;
    logic [15:0] c;
    n = 0; first_w = -1; nlines = 0; pe = 0; t_prev = 0; t_last = 0; err = 1'b0;
    c = 16'hFFFF; e = '0; done = 1'b0;
    for (int ln = 0; ln < act + 4; ln++) begin
      int y, len, llen, hs0, w;
      y = ln - 2;
      len = 0;
      if (ln >= 2 && ln < act + 2) begin
        len = H_ACT;
        if (y == 0 && first_len >= 0) len = first_len;
        if (y == short_y) len = short_len;
      end
      llen = (len + 40 > H_TOT) ? len + 40 : H_TOT;
      hs0 = llen - 30;
      for (int cc = 0; cc < llen; cc++) begin
        logic d, h, v;
        logic [8:0] p;
        if (abort_after >= 0 && n >= abort_after) return;
        d = (cc < len);
        h = !(cc >= hs0 && cc < hs0 + 20);
        v = (ln != 0);
        p = d ? pixel_for(kind, cc, y) : 9'h000;
        drive(d, h, v, p);
        if (!h && prev_hs) begin t_prev = t_last; t_last = cyc; end
        prev_hs = h;
        if (d) begin
          c = crc_model(c, p);
          if (p != bar_rgb(cc > 1023 ? 1023 : cc)) pe++;
        end
        n++;
      end
      if (len > 0) begin
        w = (len > 1023) ? 1023 : len;
        nlines++;
        if (first_w < 0) first_w = w;
        else if (w != first_w) err = 1'b1;
      end
    end
    diff = t_last - t_prev;
    e.width  = (first_w < 0) ? 10'd0 : 10'(first_w);
    e.lines  = 10'(nlines);
    e.htotal = (diff > 1023) ? 10'd1023 : 10'(diff);
    e.sig    = c;
    e.fmt_ok = (first_w == H_ACT) && (nlines == V_ACT) && !err;
    e.stable = have_prev && (c == prev_sig);
    m_count  = m_count + 16'd1;
    e.count  = m_count;
`ifdef CHK_COLOUR_BAR_EN
    e.pix = (pe > 65535) ? 16'hFFFF : 16'(pe);
`else
    e.pix = 16'd0;
`endif
    have_prev = 1'b1;
    prev_sig  = c;
    done      = 1'b1;
  endtask

  task automatic do_reset();
    hold_check();
    @(posedge clk_pix);
    #1;
    reset = 1'b1;
    vif.de = 1'b0; vif.hsync = 1'b1; vif.vsync = 1'b1;
    {vif.rgb_r, vif.rgb_g, vif.rgb_b} = 9'h000;
    prev_hs = 1'b1;
    repeat (3) @(posedge clk_pix);
    #1;
    cmp("reset_frame_done", 32'(frame_done), 0);
    cmp("reset_width", 32'(meas_width), 0);
    cmp("reset_lines", 32'(meas_lines), 0);
    cmp("reset_htotal", 32'(meas_htotal), 0);
    cmp("reset_sig", 32'(frame_sig), 0);
    cmp("reset_fmt_ok", 32'(fmt_ok), 0);
    cmp("reset_stable", 32'(sig_stable), 0);
    cmp("reset_count", 32'(frame_count), 0);
    cmp("reset_pix_err", 32'(pix_err_count), 0);
    cmp("reset_state", 32'(dbg_state), 0);
    cmp("reset_pending", 32'(exp_q.size()), 0);
    exp_q.delete();
    last_out  = '0;
    hold_bad  = 1'b0;
    have_prev = 1'b0;
    prev_sig  = '0;
    m_count   = '0;
    reset = 1'b0;
    repeat (2) drive(1'b0, 1'b1, 1'b1, 9'h000);
  endtask

  // ---- scoreboard monitor (samples on the falling edge) ----
  always @(negedge clk_pix) begin
    exp_t cur, e;
    cur = {meas_width, meas_lines, meas_htotal, frame_sig, fmt_ok, sig_stable, frame_count, pix_err_count};
    if (!reset) begin
      if (frame_done) begin
        hold_check();
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_done: frame_count=%0d, no frame expected (t=%0t)", frame_count, $time);
        end else begin
          e = exp_q.pop_front();
          cmp("meas_width", 32'(meas_width), 32'(e.width));
          cmp("meas_lines", 32'(meas_lines), 32'(e.lines));
          cmp("meas_htotal", 32'(meas_htotal), 32'(e.htotal));
          cmp("frame_sig", 32'(frame_sig), 32'(e.sig));
          cmp("fmt_ok", 32'(fmt_ok), 32'(e.fmt_ok));
          cmp("sig_stable", 32'(sig_stable), 32'(e.stable));
          cmp("frame_count", 32'(frame_count), 32'(e.count));
          cmp("pix_err_count", 32'(pix_err_count), 32'(e.pix));
        end
        last_out = cur;
      end else if (cur != last_out && !hold_bad) begin
        hold_bad = 1'b1;
        hold_act = cur;
        hold_exp = last_out;
      end
    end
  end

  // ---- stimulus ----
  row_t tbl[10];

  initial begin
    exp_t e;
    logic ok;

    tbl[0] = '{0, 4, -1, -1, 0, 10'd200, 10'd4, 1'b1, 1'b0};
    tbl[1] = '{0, 4, -1, -1, 0, 10'd200, 10'd4, 1'b1, 1'b1};
    tbl[2] = '{1, 4, -1, -1, 0, 10'd200, 10'd4, 1'b1, 1'b0};
    tbl[3] = '{1, 4, -1, -1, 0, 10'd200, 10'd4, 1'b1, 1'b1};
    tbl[4] = '{0, 4, -1, 2, 199, 10'd200, 10'd4, 1'b0, 1'b0};
    tbl[5] = '{0, 4, -1, -1, 0, 10'd200, 10'd4, 1'b1, 1'b0};
    tbl[6] = '{0, 0, -1, -1, 0, 10'd0, 10'd0, 1'b0, 1'b0};
    tbl[7] = '{3, 4, -1, -1, 0, 10'd200, 10'd4, 1'b1, 1'b0};
    tbl[8] = '{4, 4, -1, -1, 0, 10'd200, 10'd4, 1'b1, 1'b0};
    tbl[9] = '{0, 4, 150, -1, 0, 10'd150, 10'd4, 1'b0, 1'b0};

    vif.de = 1'b0; vif.hsync = 1'b1; vif.vsync = 1'b1;
    {vif.rgb_r, vif.rgb_g, vif.rgb_b} = 9'h000;
    do_reset();

    // Table-driven scenarios.
    for (int i = 0; i < 10; i++) begin
      send_frame(tbl[i].kind, tbl[i].act, tbl[i].first_len, tbl[i].short_y, tbl[i].short_len, -1, e, ok);
      e.width  = tbl[i].width;
      e.lines  = tbl[i].lines;
      e.fmt_ok = tbl[i].fmt_ok;
      e.stable = tbl[i].stable;
      exp_q.push_back(e);
    end

    // Random content and geometry against the model.
    for (int i = 0; i < 6; i++) begin
      send_frame(2, $urandom_range(1, 4), -1, $urandom_range(0, 4), $urandom_range(190, 200), -1, e, ok);
      exp_q.push_back(e);
    end

    // First line held active 1100 clocks: width saturates at 1023.
    send_frame(0, 4, 1100, -1, 0, -1, e, ok);
    exp_q.push_back(e);

    // frame_count preset to 0xFFFF mid-frame; this frame reports the wrap to 0.
    fork
      begin
        send_frame(0, 4, -1, -1, 0, -1, e, ok);
        exp_q.push_back(e);
      end
      begin
        repeat (100) @(posedge clk_pix);
        #1;
        force dut.frame_count = 16'hFFFF;
        m_count = 16'hFFFF;
        last_out.count = 16'hFFFF;
        @(posedge clk_pix);
        #1;
        release dut.frame_count;
      end
    join

    // Reset mid-frame: partial frame discarded, first frame after reset counts 1.
    send_frame(0, 4, -1, -1, 0, 300, e, ok);
    do_reset();
    send_frame(0, 4, -1, -1, 0, -1, e, ok);
    exp_q.push_back(e);
    send_frame(0, 4, -1, -1, 0, -1, e, ok);
    exp_q.push_back(e);
    send_frame(0, 4, -1, -1, 0, 3, e, ok);
    repeat (5) drive(1'b0, 1'b1, 1'b1, 9'h000);

    hold_check();
    cmp("pending_frames", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
